data_fifo: RTL

- Synchronous FIFO buffering WIDTH-bit data words between a producer stage and a consumer stage, on a single clock.
- Storage is a register array (mem[0:DEPTH-1]) addressed by wrapping read/write pointers.
- Reports occupancy, full/empty and sticky overflow/underflow error flags.
- Read data is registered: it is valid one cycle after the read is accepted.

---
 rtl/data_fifo.sv | 53 +++++
 1 files changed

// File: rtl/data_fifo.sv
// data_fifo: single-clock FIFO with registered read data, occupancy and sticky error flags
module data_fifo #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en,
  output logic [WIDTH-1:0]  rd_data,
  output logic              rd_valid,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow,
  input  logic              clr_err
);
  logic [WIDTH-1:0]  mem [0:DEPTH-1];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic              wr_acc, rd_acc;
  assign full   = count == (ADDR_W+1)'(DEPTH);
  assign empty  = count == '0;
  assign rd_acc = rd_en & ~empty;
  assign wr_acc = wr_en & (~full | rd_acc);
  always_ff @(posedge clk)
    if (wr_acc) mem[wr_ptr] <= wr_data;
  // pointers wrap naturally because DEPTH == 2**ADDR_W
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      rd_data   <= '0;
      rd_valid  <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (rd_acc) begin
        rd_ptr  <= rd_ptr + ADDR_W'(1);
        rd_data <= mem[rd_ptr];
      end
      rd_valid  <= rd_acc;
      count     <= wr_acc & ~rd_acc ? count + (ADDR_W+1)'(1) :
                   rd_acc & ~wr_acc ? count - (ADDR_W+1)'(1) : count;
      overflow  <= (wr_en & ~wr_acc) | (overflow & ~clr_err);
      underflow <= (rd_en & ~rd_acc) | (underflow & ~clr_err);
    end
  end
endmodule
